// File: rtl/isb_prefetcher.sv
// rtl/isb_prefetcher.sv - PC-localised irregular stream buffer prefetcher
// Purpose: trains per-PC temporal streams into structural address space and
//          replays up to DEGREE structural successors of each access.
// Ports:   clk, rst                 clock, asynchronous active-high reset
//          v_in, pc, addr, in_ready access event input (accept on v_in & in_ready)
//          prefetch_v, prefetch_addr, prefetch_ready  registered prefetch output
// Option:  ISB_DEDUP_EN - skip candidates matching the last 4 issued addresses.
module isb_prefetcher #(
    parameter int ADDR_W      = 16,
    parameter int SADDR_W     = 16,
    parameter int PS_ENTRIES  = 32,
    parameter int SP_ENTRIES  = 32,
    parameter int TU_ENTRIES  = 4,
    parameter int STREAM_LOG2 = 4,
    parameter int DEGREE      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              v_in,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] addr,
    output logic              in_ready,
    output logic              prefetch_v,
    output logic [ADDR_W-1:0] prefetch_addr,
    input  logic              prefetch_ready
);
    localparam int PS_IW = $clog2(PS_ENTRIES);
    localparam int SP_IW = $clog2(SP_ENTRIES);
    localparam int TU_IW = (TU_ENTRIES > 1) ? $clog2(TU_ENTRIES) : 1;
    localparam int K_W   = 4;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    // Tables: valid bits are reset, payloads are plain storage.
    logic [PS_ENTRIES-1:0] ps_v_q, ps_v_d;
    logic [ADDR_W-1:0]     ps_tag_q [PS_ENTRIES], ps_tag_d [PS_ENTRIES];
    logic [SADDR_W-1:0]    ps_s_q   [PS_ENTRIES], ps_s_d   [PS_ENTRIES];
    logic [1:0]            ps_conf_q[PS_ENTRIES], ps_conf_d[PS_ENTRIES];
    logic [SP_ENTRIES-1:0] sp_v_q, sp_v_d;
    logic [SADDR_W-1:0]    sp_tag_q [SP_ENTRIES], sp_tag_d [SP_ENTRIES];
    logic [ADDR_W-1:0]     sp_pa_q  [SP_ENTRIES], sp_pa_d  [SP_ENTRIES];
    logic [TU_ENTRIES-1:0] tu_v_q, tu_v_d;
    logic [ADDR_W-1:0]     tu_pc_q  [TU_ENTRIES], tu_pc_d  [TU_ENTRIES];
    logic [ADDR_W-1:0]     tu_last_q[TU_ENTRIES], tu_last_d[TU_ENTRIES];
    logic [TU_IW-1:0]      rr_q, rr_d;
    logic [SADDR_W-1:0]    nxt_s_q, nxt_s_d;

    state_t                state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [SADDR_W-1:0]    sb_q, sb_d;
    logic                  pv_q, pv_d;
    logic [ADDR_W-1:0]     pa_q, pa_d;

    // Training intermediates
    logic                  accept, tu_hit, tu_free, train;
    logic [TU_IW-1:0]      tu_idx, tu_free_idx, victim;
    logic [ADDR_W-1:0]     a_addr;
    logic [PS_IW-1:0]      ia, ib;
    logic                  a_hit, b_hit, a_new, b_new, b_inc, b_dec, chunk_full;
    logic [SADDR_W-1:0]    s_a, s_a1, b_s, s_b;
    logic [1:0]            b_conf;
    logic                  b_post_hit;

    // Issue intermediates
    logic [SADDR_W-1:0]    cand;
    logic [SP_IW-1:0]      ic;
    logic                  cand_v, last_k, issued;

`ifdef ISB_DEDUP_EN
    logic [3:0]            dd_v_q, dd_v_d;
    logic [ADDR_W-1:0]     dd_a_q[4], dd_a_d[4];
`endif

    assign in_ready      = (state_q == S_IDLE);
    assign accept        = v_in && in_ready;
    assign prefetch_v    = pv_q;
    assign prefetch_addr = pa_q;

    always_comb begin
        ps_v_d = ps_v_q; ps_tag_d = ps_tag_q; ps_s_d = ps_s_q; ps_conf_d = ps_conf_q;
        sp_v_d = sp_v_q; sp_tag_d = sp_tag_q; sp_pa_d = sp_pa_q;
        tu_v_d = tu_v_q; tu_pc_d = tu_pc_q; tu_last_d = tu_last_q;
        rr_d = rr_q; nxt_s_d = nxt_s_q;

        tu_hit = 1'b0; tu_idx = '0;
        tu_free = 1'b0; tu_free_idx = '0;
        for (int i = 0; i < TU_ENTRIES; i++) begin
            if (!tu_hit && tu_v_q[i] && tu_pc_q[i] == pc) begin
                tu_hit = 1'b1; tu_idx = TU_IW'(i);
            end
            if (!tu_free && !tu_v_q[i]) begin
                tu_free = 1'b1; tu_free_idx = TU_IW'(i);
            end
        end
        victim = tu_free ? tu_free_idx : rr_q;

        a_addr = tu_last_q[tu_idx];
        ia     = a_addr[PS_IW-1:0];
        ib     = addr[PS_IW-1:0];
        a_hit  = ps_v_q[ia] && ps_tag_q[ia] == a_addr;
        b_hit  = ps_v_q[ib] && ps_tag_q[ib] == addr;
        b_s    = ps_s_q[ib];
        b_conf = ps_conf_q[ib];

        train      = accept && tu_hit && (a_addr != addr);
        a_new      = train && !a_hit;
        s_a        = a_hit ? ps_s_q[ia] : nxt_s_q;
        s_a1       = s_a + SADDR_W'(1);
        chunk_full = &s_a[STREAM_LOG2-1:0];
        b_new = train && !chunk_full && (!b_hit || (b_conf == 2'd0 && b_s != s_a1));
        b_inc = train && !chunk_full && !b_new && (b_s == s_a1);
        b_dec = train && !chunk_full && !b_new && !b_inc;

        if (a_new) begin
            ps_v_d[ia] = 1'b1; ps_tag_d[ia] = a_addr; ps_s_d[ia] = s_a; ps_conf_d[ia] = 2'd1;
            sp_v_d[s_a[SP_IW-1:0]]   = 1'b1;
            sp_tag_d[s_a[SP_IW-1:0]] = s_a;
            sp_pa_d[s_a[SP_IW-1:0]]  = a_addr;
            nxt_s_d = nxt_s_q + SADDR_W'(1 << STREAM_LOG2);
        end
        // B updates come second so they win any same-index collision with A;
        // conf updates rewrite the whole entry for the same reason.
        if (b_new) begin
            ps_v_d[ib] = 1'b1; ps_tag_d[ib] = addr; ps_s_d[ib] = s_a1; ps_conf_d[ib] = 2'd1;
            sp_v_d[s_a1[SP_IW-1:0]]   = 1'b1;
            sp_tag_d[s_a1[SP_IW-1:0]] = s_a1;
            sp_pa_d[s_a1[SP_IW-1:0]]  = addr;
        end else if (b_inc || b_dec) begin
            ps_v_d[ib] = 1'b1; ps_tag_d[ib] = addr; ps_s_d[ib] = b_s;
            if (b_inc) ps_conf_d[ib] = (b_conf == 2'd3) ? 2'd3 : b_conf + 2'd1;
            else       ps_conf_d[ib] = b_conf - 2'd1;
        end

        if (accept) begin
            if (tu_hit) begin
                tu_last_d[tu_idx] = addr;
            end else begin
                tu_v_d[victim] = 1'b1; tu_pc_d[victim] = pc; tu_last_d[victim] = addr;
                rr_d = (victim == TU_IW'(TU_ENTRIES - 1)) ? '0 : victim + TU_IW'(1);
            end
        end

        // Prediction uses B's mapping as it will stand after this edge.
        b_post_hit = ps_v_d[ib] && ps_tag_d[ib] == addr;
        s_b        = ps_s_d[ib];
    end

    always_comb begin
        state_d = state_q; k_d = k_q; sb_d = sb_q; pv_d = pv_q; pa_d = pa_q;
        issued  = 1'b0;

        cand   = sb_q + SADDR_W'(k_q);
        ic     = cand[SP_IW-1:0];
        cand_v = (cand[SADDR_W-1:STREAM_LOG2] == sb_q[SADDR_W-1:STREAM_LOG2])
                 && sp_v_q[ic] && sp_tag_q[ic] == cand;
`ifdef ISB_DEDUP_EN
        for (int j = 0; j < 4; j++)
            if (dd_v_q[j] && dd_a_q[j] == sp_pa_q[ic]) cand_v = 1'b0;
`endif
        last_k = (k_q == K_W'(DEGREE));

        case (state_q)
            S_IDLE: begin
                if (accept && b_post_hit) begin
                    state_d = S_ISSUE; sb_d = s_b; k_d = K_W'(1);
                end
            end
            S_ISSUE: begin
                if (pv_q) begin
                    if (prefetch_ready) begin
                        pv_d = 1'b0; issued = 1'b1;
                        if (last_k) state_d = S_IDLE;
                        else        k_d = k_q + K_W'(1);
                    end
                end else if (cand_v) begin
                    pv_d = 1'b1; pa_d = sp_pa_q[ic];
                end else if (last_k) begin
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ISB_DEDUP_EN
        dd_v_d = dd_v_q; dd_a_d = dd_a_q;
        if (issued) begin
            dd_v_d = {dd_v_q[2:0], 1'b1};
            dd_a_d[0] = pa_q;
            for (int j = 1; j < 4; j++) dd_a_d[j] = dd_a_q[j-1];
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_v_q <= '0; sp_v_q <= '0; tu_v_q <= '0;
            rr_q <= '0; nxt_s_q <= '0;
            state_q <= S_IDLE; k_q <= '0; sb_q <= '0; pv_q <= 1'b0; pa_q <= '0;
`ifdef ISB_DEDUP_EN
            dd_v_q <= '0;
`endif
        end else begin
            ps_v_q <= ps_v_d; sp_v_q <= sp_v_d; tu_v_q <= tu_v_d;
            rr_q <= rr_d; nxt_s_q <= nxt_s_d;
            state_q <= state_d; k_q <= k_d; sb_q <= sb_d; pv_q <= pv_d; pa_q <= pa_d;
`ifdef ISB_DEDUP_EN
            dd_v_q <= dd_v_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        ps_tag_q <= ps_tag_d; ps_s_q <= ps_s_d; ps_conf_q <= ps_conf_d;
        sp_tag_q <= sp_tag_d; sp_pa_q <= sp_pa_d;
        tu_pc_q <= tu_pc_d; tu_last_q <= tu_last_d;
`ifdef ISB_DEDUP_EN
        dd_a_q <= dd_a_d;
`endif
    end
endmodule
